initialization_command_word_sequencer: RTL and testbench
========================================================

Name: initialization_command_word_sequencer

Overview:
- Clocked successor to the ICW1 capture logic. Sequences the full 8259A initialization ICW1 -> ICW2 -> [ICW3] -> [ICW4] and holds every configuration field in flops.
- Reports initialization state and routes post-init A0=1 writes to OCW1.
- Sits in the control-logic block, between the bus/R-W decode and the priority/cascade/IMR logic.

Parameters:
DATA_WIDTH, 8, internal data bus width; must be >= 8.
CASCADE_WIDTH, 8, width of the ICW3 master slave-presence mask (1..8).
SLAVE_ID_WIDTH, 3, width of the ICW3 slave ID field (1..3).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
write_initial_command_word_1  input  1  one-cycle strobe: A0=0, D4=1 write
write_initial_command_word_2_to_4  input  1  one-cycle strobe: A0=1 write
internal_data_bus  input  DATA_WIDTH  write data
interrupt_vector_address  output  11  {ICW2[7:0], ICW1[7:5]}
level_or_edge_triggered_config  output  1  ICW1 LTIM
call_address_interval_4_or_8_config  output  1  ICW1 ADI
single_or_cascade_config  output  1  ICW1 SNGL
set_icw4_config  output  1  ICW1 IC4
cascade_device_config  output  CASCADE_WIDTH  ICW3, master view
slave_id_config  output  SLAVE_ID_WIDTH  ICW3[SLAVE_ID_WIDTH-1:0]
u8086_or_mcs80_config  output  1  ICW4 uPM
auto_eoi_config  output  1  ICW4 AEOI
buffered_master_or_slave_config  output  1  ICW4 M/S
buffered_mode_config  output  1  ICW4 BUF
special_fully_nested_config  output  1  ICW4 SFNM
initialization_reset_pulse  output  1  one cycle after any ICW1 capture
write_operation_control_word_1  output  1  one-cycle pulse: A0=1 write while READY
initialization_busy  output  1  state is not IDLE and not READY
initialization_done  output  1  state is READY

Behaviour:
- State machine: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- Reset: state=IDLE; all config outputs 0; pulses 0; busy=0; done=0.
- All outputs are registered and update on the clock edge after the strobe (latency 1).
- ICW1 strobe, in any state:
  - Capture LTIM/ADI/SNGL/IC4 and vector bits [7:5]; clear ICW2/3/4 fields to 0.
  - Next state is WAIT_ICW2; pulse initialization_reset_pulse for one cycle.
  - An ICW1 during an in-progress sequence restarts it.
- A0 strobe in WAIT_ICW2: capture ICW2 into vector[10:3]. Next state:
  - SNGL=0 -> WAIT_ICW3
  - else IC4=1 -> WAIT_ICW4
  - else READY
- A0 strobe in WAIT_ICW3: capture cascade_device_config = data[CASCADE_WIDTH-1:0] and slave_id_config = data[SLAVE_ID_WIDTH-1:0]. Next state is WAIT_ICW4 if IC4=1, else READY.
- A0 strobe in WAIT_ICW4: capture data[4:0] as SFNM, BUF, M/S, AEOI, uPM (bits 4..0). Next state is READY.
- IC4=0: ICW4 fields stay 0 (uPM=0, MCS-80 mode).
- A0 strobe in READY: assert write_operation_control_word_1 for one cycle; config unchanged.
- A0 strobe in IDLE: ignored.
- Both strobes in the same cycle: ICW1 wins; the A0 write is dropped and no OCW1 pulse is produced.
- Reset asserted mid-sequence: immediate return to the reset values; done deasserts asynchronously.
- Strobes longer than one cycle are treated as repeated writes; the upstream decode guarantees single-cycle strobes.

Optional Feature:
Macro: ICW_READBACK_EN.
- Defined: adds input read_icw_select[1:0] and output icw_readback_data[7:0].
  - Combinational mux: 0 -> ICW1 image {vector[2:0],0,LTIM,ADI,SNGL,IC4}; 1 -> ICW2; 2 -> ICW3 (zero-extended); 3 -> {000,ICW4[4:0]}.
  - Drives 0 while reset is asserted.
- Undefined: neither port exists; the core behaviour is identical.

Decomposition:
- Shared package icw_pkg holds:
  - state enum icw_state_t
  - ICW1 bit positions (IC4=0, SNGL=1, ADI=2, LTIM=3, ICW1_FLAG=4)
  - ICW4 bit positions (uPM=0, AEOI=1, MS=2, BUF=3, SFNM=4)
  - vector field widths
- One sub-module, icw_next_state: purely combinational next-state/capture-enable decode. Register storage stays in the top.

Test Plan:
- Single, no ICW4: ICW1=0x1A (SNGL=1, LTIM=1, IC4=0) then ICW2=0x20 -> READY; vector=0x100, LTIM=1, SNGL=1, uPM=0, done=1 after the 2nd write.
- Cascade with ICW4: ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x03 -> states step WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY; cascade=0x04, slave_id=4, AEOI=1, uPM=1.
- Restart: ICW1=0x11, ICW2=0x08, then ICW1=0x13 -> WAIT_ICW2, ICW2/3 fields cleared, reset pulse seen twice, done never asserted.
- Post-init write: A0 strobe with data 0xFF in READY -> write_operation_control_word_1 high for exactly one cycle; config unchanged.
- Collision: both strobes in the same cycle while READY -> ICW1 captured, state WAIT_ICW2, no OCW1 pulse.
- Async reset: assert reset in WAIT_ICW3 between clock edges -> outputs go to 0 and done=0 with no clock edge; a fresh sequence then completes normally.

Source files
------------

// File: rtl/initialization_command_word_sequencer_pkg.sv
// Shared types and field positions for the 8259A initialization sequencer.
// Optional build macro used elsewhere: ICW_READBACK_EN (ICW image read-back mux).
package icw_pkg;

    // Initialization sequence position
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } icw_state_t;

    // ICW1 bit positions
    localparam int unsigned ICW1_IC4_BIT  = 0;
    localparam int unsigned ICW1_SNGL_BIT = 1;
    localparam int unsigned ICW1_ADI_BIT  = 2;
    localparam int unsigned ICW1_LTIM_BIT = 3;
    localparam int unsigned ICW1_FLAG_BIT = 4;

    // ICW4 bit positions
    localparam int unsigned ICW4_UPM_BIT  = 0;
    localparam int unsigned ICW4_AEOI_BIT = 1;
    localparam int unsigned ICW4_MS_BIT   = 2;
    localparam int unsigned ICW4_BUF_BIT  = 3;
    localparam int unsigned ICW4_SFNM_BIT = 4;

    // Vector address and ICW field widths
    localparam int unsigned ICW_BYTE_WIDTH    = 8;
    localparam int unsigned VECTOR_LOW_WIDTH  = 3;
    localparam int unsigned VECTOR_HIGH_WIDTH = 8;
    localparam int unsigned VECTOR_WIDTH      = VECTOR_HIGH_WIDTH + VECTOR_LOW_WIDTH;
    localparam int unsigned ICW1_VECTOR_LSB   = 5;
    localparam int unsigned ICW4_FIELD_WIDTH  = 5;

    // Rebuild the ICW1 byte image from its stored fields (flag bit reads as 0)
    function automatic logic [ICW_BYTE_WIDTH-1:0] icw1_image(
        input logic [VECTOR_LOW_WIDTH-1:0] vector_low,
        input logic                        ltim,
        input logic                        adi,
        input logic                        sngl,
        input logic                        ic4
    );
        logic [ICW_BYTE_WIDTH-1:0] image;
        image                    = '0;
        image[7:5]               = vector_low;
        image[ICW1_FLAG_BIT]     = 1'b0;
        image[ICW1_LTIM_BIT]     = ltim;
        image[ICW1_ADI_BIT]      = adi;
        image[ICW1_SNGL_BIT]     = sngl;
        image[ICW1_IC4_BIT]      = ic4;
        return image;
    endfunction

endpackage

// File: rtl/initialization_command_word_sequencer_next_state.sv
// Combinational next-state and capture-enable decode for the ICW sequencer.
module icw_next_state
    import icw_pkg::*;
(
    input  icw_state_t state,
    input  logic       write_icw1,
    input  logic       write_icw2_to_4,
    input  logic       single_mode,
    input  logic       icw4_needed,
    output icw_state_t next_state,
    output logic       capture_icw1,
    capture_icw2,
    output logic       capture_icw3,
    output logic       capture_icw4,
    output logic       ocw1_write
);

    // ICW1 always wins and restarts; A0 writes advance the sequence or become OCW1
    always_comb begin
        next_state   = state;
        capture_icw1 = 1'b0;
        capture_icw2 = 1'b0;
        capture_icw3 = 1'b0;
        capture_icw4 = 1'b0;
        ocw1_write   = 1'b0;
        if (write_icw1) begin
            capture_icw1 = 1'b1;
            next_state   = WAIT_ICW2;
        end else if (write_icw2_to_4) begin
            case (state)
                WAIT_ICW2: begin
                    capture_icw2 = 1'b1;
                    if (!single_mode) begin
                        next_state = WAIT_ICW3;
                    end else if (icw4_needed) begin
                        next_state = WAIT_ICW4;
                    end else begin
                        next_state = READY;
                    end
                end
                WAIT_ICW3: begin
                    capture_icw3 = 1'b1;
                    next_state   = icw4_needed ? WAIT_ICW4 : READY;
                end
                WAIT_ICW4: begin
                    capture_icw4 = 1'b1;
                    next_state   = READY;
                end
                READY: begin
                    ocw1_write = 1'b1;
                end
                default: begin
                    next_state = state;
                end
            endcase
        end
    end

endmodule

// File: rtl/initialization_command_word_sequencer.sv
// 8259A initialization command word sequencer: ICW1 -> ICW2 -> [ICW3] -> [ICW4],
// holds all configuration fields in flops and routes post-init A0 writes to OCW1.
// Optional build macro: ICW_READBACK_EN adds read_icw_select / icw_readback_data.
module initialization_command_word_sequencer
    import icw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CASCADE_WIDTH  = 8,
    parameter int unsigned SLAVE_ID_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      reset,
`ifdef ICW_READBACK_EN
    input  logic [1:0]                read_icw_select,
    output logic [7:0]                icw_readback_data,
`endif
    input  logic                      write_initial_command_word_1,
    input  logic                      write_initial_command_word_2_to_4,
    input  logic [DATA_WIDTH-1:0]     internal_data_bus,
    output logic [VECTOR_WIDTH-1:0]   interrupt_vector_address,
    output logic                      level_or_edge_triggered_config,
    output logic                      call_address_interval_4_or_8_config,
    output logic                      single_or_cascade_config,
    output logic                      set_icw4_config,
    output logic [CASCADE_WIDTH-1:0]  cascade_device_config,
    output logic [SLAVE_ID_WIDTH-1:0] slave_id_config,
    output logic                      u8086_or_mcs80_config,
    output logic                      auto_eoi_config,
    output logic                      buffered_master_or_slave_config,
    output logic                      buffered_mode_config,
    output logic                      special_fully_nested_config,
    output logic                      initialization_reset_pulse,
    output logic                      write_operation_control_word_1,
    output logic                      initialization_busy,
    output logic                      initialization_done
);

    icw_state_t state;
    icw_state_t next_state;
    logic       capture_icw1;
    logic       capture_icw2;
    logic       capture_icw3;
    logic       capture_icw4;
    logic       ocw1_write;

    logic [ICW_BYTE_WIDTH-1:0] write_byte;
    assign write_byte = internal_data_bus[ICW_BYTE_WIDTH-1:0];

    // Sequence decode
    icw_next_state u_next_state (
        .state           (state),
        .write_icw1      (write_initial_command_word_1),
        .write_icw2_to_4 (write_initial_command_word_2_to_4),
        .single_mode     (single_or_cascade_config),
        .icw4_needed     (set_icw4_config),
        .next_state      (next_state),
        .capture_icw1    (capture_icw1),
        .capture_icw2    (capture_icw2),
        .capture_icw3    (capture_icw3),
        .capture_icw4    (capture_icw4),
        .ocw1_write      (ocw1_write)
    );

    // State, status flags and one-cycle pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                          <= IDLE;
            initialization_busy            <= 1'b0;
            initialization_done            <= 1'b0;
            initialization_reset_pulse     <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
        end else begin
            state                          <= next_state;
            initialization_busy            <= (next_state != IDLE) && (next_state != READY);
            initialization_done            <= (next_state == READY);
            initialization_reset_pulse     <= capture_icw1;
            write_operation_control_word_1 <= ocw1_write;
        end
    end

    // ICW1 fields; low vector bits come from ICW1[7:5]
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            interrupt_vector_address[VECTOR_LOW_WIDTH-1:0] <= '0;
            level_or_edge_triggered_config                 <= 1'b0;
            call_address_interval_4_or_8_config            <= 1'b0;
            single_or_cascade_config                       <= 1'b0;
            set_icw4_config                                <= 1'b0;
        end else if (capture_icw1) begin
            interrupt_vector_address[VECTOR_LOW_WIDTH-1:0] <= write_byte[7:ICW1_VECTOR_LSB];
            level_or_edge_triggered_config                 <= write_byte[ICW1_LTIM_BIT];
            call_address_interval_4_or_8_config            <= write_byte[ICW1_ADI_BIT];
            single_or_cascade_config                       <= write_byte[ICW1_SNGL_BIT];
            set_icw4_config                                <= write_byte[ICW1_IC4_BIT];
        end
    end

    // ICW2: upper vector bits, cleared by a new ICW1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            interrupt_vector_address[VECTOR_WIDTH-1:VECTOR_LOW_WIDTH] <= '0;
        end else if (capture_icw1) begin
            interrupt_vector_address[VECTOR_WIDTH-1:VECTOR_LOW_WIDTH] <= '0;
        end else if (capture_icw2) begin
            interrupt_vector_address[VECTOR_WIDTH-1:VECTOR_LOW_WIDTH] <= write_byte;
        end
    end

    // ICW3: master presence mask and slave ID share the same written byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cascade_device_config <= '0;
            slave_id_config       <= '0;
        end else if (capture_icw1) begin
            cascade_device_config <= '0;
            slave_id_config       <= '0;
        end else if (capture_icw3) begin
            cascade_device_config <= write_byte[CASCADE_WIDTH-1:0];
            slave_id_config       <= write_byte[SLAVE_ID_WIDTH-1:0];
        end
    end

    // ICW4: stays zero (MCS-80 mode) when no ICW4 is requested
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            u8086_or_mcs80_config           <= 1'b0;
            auto_eoi_config                 <= 1'b0;
            buffered_master_or_slave_config <= 1'b0;
            buffered_mode_config            <= 1'b0;
            special_fully_nested_config     <= 1'b0;
        end else if (capture_icw1) begin
            u8086_or_mcs80_config           <= 1'b0;
            auto_eoi_config                 <= 1'b0;
            buffered_master_or_slave_config <= 1'b0;
            buffered_mode_config            <= 1'b0;
            special_fully_nested_config     <= 1'b0;
        end else if (capture_icw4) begin
            u8086_or_mcs80_config           <= write_byte[ICW4_UPM_BIT];
            auto_eoi_config                 <= write_byte[ICW4_AEOI_BIT];
            buffered_master_or_slave_config <= write_byte[ICW4_MS_BIT];
            buffered_mode_config            <= write_byte[ICW4_BUF_BIT];
            special_fully_nested_config     <= write_byte[ICW4_SFNM_BIT];
        end
    end

`ifdef ICW_READBACK_EN
    // Read-back mux of the stored ICW images, forced to zero during reset
    always_comb begin
        icw_readback_data = '0;
        if (!reset) begin
            case (read_icw_select)
                2'd0: icw_readback_data = icw1_image(
                          interrupt_vector_address[VECTOR_LOW_WIDTH-1:0],
                          level_or_edge_triggered_config,
                          call_address_interval_4_or_8_config,
                          single_or_cascade_config,
                          set_icw4_config);
                2'd1: icw_readback_data = interrupt_vector_address[VECTOR_WIDTH-1:VECTOR_LOW_WIDTH];
                2'd2: icw_readback_data = 8'(cascade_device_config);
                default: icw_readback_data = {3'b000,
                                              special_fully_nested_config,
                                              buffered_mode_config,
                                              buffered_master_or_slave_config,
                                              auto_eoi_config,
                                              u8086_or_mcs80_config};
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_initialization_command_word_sequencer.sv
// Self-checking bench for initialization_command_word_sequencer: directed test-plan
// sequences plus randomized strobes against a queue-based model of pending ICWs.
module tb_initialization_command_word_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          w1;
    logic          w24;
    logic [DW-1:0] data;

    logic [10:0]   vector;
    logic          ltim, adi, sngl, ic4;
    logic [CW-1:0] cascade;
    logic [SW-1:0] slave_id;
    logic          upm, aeoi, ms, bufm, sfnm;
    logic          rst_pulse, ocw1, busy, done;

    initialization_command_word_sequencer #(
        .DATA_WIDTH(DW), .CASCADE_WIDTH(CW), .SLAVE_ID_WIDTH(SW)
    ) dut (
        .clock                               (clock),
        .reset                               (reset),
        .write_initial_command_word_1        (w1),
        .write_initial_command_word_2_to_4   (w24),
        .internal_data_bus                   (data),
        .interrupt_vector_address            (vector),
        .level_or_edge_triggered_config      (ltim),
        .call_address_interval_4_or_8_config (adi),
        .single_or_cascade_config            (sngl),
        .set_icw4_config                     (ic4),
        .cascade_device_config               (cascade),
        .slave_id_config                     (slave_id),
        .u8086_or_mcs80_config               (upm),
        .auto_eoi_config                     (aeoi),
        .buffered_master_or_slave_config     (ms),
        .buffered_mode_config                (bufm),
        .special_fully_nested_config         (sfnm),
        .initialization_reset_pulse          (rst_pulse),
        .write_operation_control_word_1      (ocw1),
        .initialization_busy                 (busy),
        .initialization_done                 (done)
    );

    always #5 clock = ~clock;

    // Model: raw ICW bytes plus a queue of the ICW numbers still owed
    logic [7:0] m_icw1, m_icw2, m_icw3, m_icw4;
    bit         m_started, m_rst_pulse, m_ocw1;
    int         pending[$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_icw1 = '0; m_icw2 = '0; m_icw3 = '0; m_icw4 = '0;
        m_started = 1'b0; m_rst_pulse = 1'b0; m_ocw1 = 1'b0;
        pending.delete();
    endtask

    task automatic model_update(input bit s1, input bit s24, input logic [7:0] d);
        int n;
        if (reset) return;
        m_rst_pulse = s1;
        m_ocw1      = 1'b0;
        if (s1) begin
            m_icw1 = d; m_icw2 = '0; m_icw3 = '0; m_icw4 = '0;
            m_started = 1'b1;
            pending.delete();
            pending.push_back(2);
            if (!d[1]) pending.push_back(3);
            if (d[0])  pending.push_back(4);
        end else if (s24 && m_started) begin
            if (pending.size() == 0) begin
                m_ocw1 = 1'b1;
            end else begin
                n = pending.pop_front();
                if (n == 2) m_icw2 = d;
                else if (n == 3) m_icw3 = d;
                else m_icw4 = {3'b000, d[4:0]};
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        chk("vector",    32'(vector),    32'({m_icw2, m_icw1[7:5]}));
        chk("ltim",      32'(ltim),      32'(m_icw1[3]));
        chk("adi",       32'(adi),       32'(m_icw1[2]));
        chk("sngl",      32'(sngl),      32'(m_icw1[1]));
        chk("ic4",       32'(ic4),       32'(m_icw1[0]));
        chk("cascade",   32'(cascade),   32'(m_icw3[CW-1:0]));
        chk("slave_id",  32'(slave_id),  32'(m_icw3[SW-1:0]));
        chk("upm",       32'(upm),       32'(m_icw4[0]));
        chk("aeoi",      32'(aeoi),      32'(m_icw4[1]));
        chk("ms",        32'(ms),        32'(m_icw4[2]));
        chk("buf",       32'(bufm),      32'(m_icw4[3]));
        chk("sfnm",      32'(sfnm),      32'(m_icw4[4]));
        chk("rst_pulse", 32'(rst_pulse), 32'(m_rst_pulse));
        chk("ocw1",      32'(ocw1),      32'(m_ocw1));
        chk("busy",      32'(busy),      32'(pending.size() != 0));
        chk("done",      32'(done),      32'(m_started && pending.size() == 0));
    end

    // One clock of stimulus; returns just after the rising edge
    task automatic cyc(input bit s1, input bit s24, input logic [7:0] d);
        @(negedge clock);
        w1 = s1; w24 = s24; data = d;
        @(posedge clock);
        model_update(s1, s24, d);
    endtask

    // Reset between clock edges and check outputs clear without an edge
    task automatic async_reset_mid();
        #2;
        reset = 1'b1;
        model_reset();
        w1 = 1'b0; w24 = 1'b0;
        #1;
        chk("async_done",    32'(done),    32'd0);
        chk("async_busy",    32'(busy),    32'd0);
        chk("async_vector",  32'(vector),  32'd0);
        chk("async_cascade", 32'(cascade), 32'd0);
        chk("async_sngl",    32'(sngl),    32'd0);
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; w1 = 1'b0; w24 = 1'b0; data = '0;
        model_reset();
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;

        // A0 write while IDLE is ignored
        cyc(0, 1, 8'hFF); #1;
        chk("idle_ocw1", 32'(ocw1), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // Single mode, no ICW4
        cyc(1, 0, 8'h1A); #1;
        chk("t1_pulse", 32'(rst_pulse), 32'd1);
        chk("t1_busy",  32'(busy),      32'd1);
        cyc(0, 1, 8'h20); #1;
        chk("t1_vector", 32'(vector), 32'h100);
        chk("t1_ltim",   32'(ltim),   32'd1);
        chk("t1_sngl",   32'(sngl),   32'd1);
        chk("t1_upm",    32'(upm),    32'd0);
        chk("t1_done",   32'(done),   32'd1);

        // Cascade with ICW3 and ICW4
        cyc(1, 0, 8'h11); #1;
        chk("t2_busy1", 32'(busy), 32'd1);
        cyc(0, 1, 8'h08); #1;
        chk("t2_busy2", 32'(busy), 32'd1);
        cyc(0, 1, 8'h04); #1;
        chk("t2_cascade", 32'(cascade),  32'h04);
        chk("t2_slave",   32'(slave_id), 32'd4);
        chk("t2_done3",   32'(done),     32'd0);
        cyc(0, 1, 8'h03); #1;
        chk("t2_aeoi",   32'(aeoi),   32'd1);
        chk("t2_upm",    32'(upm),    32'd1);
        chk("t2_vector", 32'(vector), 32'h040);
        chk("t2_done",   32'(done),   32'd1);

        // Restart mid-sequence
        cyc(1, 0, 8'h11); #1;
        chk("t3_pulse1", 32'(rst_pulse), 32'd1);
        cyc(0, 1, 8'h08);
        cyc(0, 0, 8'h00); #1;
        chk("t3_pulse_low", 32'(rst_pulse), 32'd0);
        cyc(1, 0, 8'h13); #1;
        chk("t3_pulse2", 32'(rst_pulse), 32'd1);
        chk("t3_vector", 32'(vector),    32'd0);
        chk("t3_done",   32'(done),      32'd0);
        cyc(0, 1, 8'h48); #1;
        chk("t3_vector2", 32'(vector), 32'h240);
        chk("t3_busy",    32'(busy),   32'd1);
        cyc(0, 1, 8'h1F); #1;
        chk("t3_sfnm", 32'(sfnm), 32'd1);
        chk("t3_done2", 32'(done), 32'd1);

        // Post-init OCW1 write
        cyc(0, 1, 8'hFF); #1;
        chk("t4_ocw1",   32'(ocw1),   32'd1);
        chk("t4_vector", 32'(vector), 32'h240);
        cyc(0, 0, 8'h00); #1;
        chk("t4_ocw1_low", 32'(ocw1), 32'd0);

        // Async reset while READY
        async_reset_mid();
        cyc(1, 0, 8'h12);
        cyc(0, 1, 8'h30); #1;
        chk("t5_ready", 32'(done), 32'd1);

        // Collision: ICW1 wins, no OCW1
        cyc(1, 1, 8'h16); #1;
        chk("t5_ocw1",  32'(ocw1),      32'd0);
        chk("t5_pulse", 32'(rst_pulse), 32'd1);
        chk("t5_busy",  32'(busy),      32'd1);
        chk("t5_adi",   32'(adi),       32'd1);

        // Async reset in WAIT_ICW3, then a fresh sequence
        cyc(1, 0, 8'h11);
        cyc(0, 1, 8'h08);
        async_reset_mid();
        cyc(1, 0, 8'h1A);
        cyc(0, 1, 8'h20); #1;
        chk("t6_vector", 32'(vector), 32'h100);
        chk("t6_done",   32'(done),   32'd1);

        // Randomized strobes and data
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
            if (i % 400 == 399) async_reset_mid();
        end
        cyc(0, 0, 8'h00);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
